uart_rx_vote3: RTL and testbench

Receive-side UART controller that sequences a 3-input majority voter over the oversampled RX line. It detects start bits, takes three samples around each bit centre, votes them through `generic__maj3`, and shifts the result into a byte. It sits between the pad-level RX input and the byte-wide receive logic, and is paced by an external oversample tick from the baud generator.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_vote3_maj3.sv | 12 +
 rtl/uart_rx_vote3.sv | 139 +++++++++++++
 tb/tb_uart_rx_vote3.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the oversampled UART receiver.
// FSM state codes and the bit-centre helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic int unsigned mid_of(
    input int unsigned os
  );
    return os / 2;
  endfunction

endpackage

// File: rtl/uart_rx_vote3_maj3.sv
// Generic 3-input majority cell; PDK flows may remap it.
// Ports: a, b, c in; y out = majority(a, b, c).
module generic__maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_rx_vote3.sv
// UART receiver voting three samples around each bit centre.
// Ports: clk, rst_n, baud_tick, rx_in in; data_out, data_valid, frame_err, busy out.
module uart_rx_vote3
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned MID = mid_of(OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_S0   = SCW'(MID - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(MID);
  localparam logic [SCW-1:0] SC_VOTE = SCW'(MID + 1);
  localparam logic [SCW-1:0] SC_ONE  = SCW'(1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);
  localparam logic [BIW-1:0] BI_ONE  = BIW'(1);

  logic                 rx_meta;
  logic                 rxs;
  logic [2:0]           state;
  logic [SCW-1:0]       sc;
  logic [BIW-1:0]       bi;
  logic                 s0;
  logic                 s1;
  logic                 vote;
  logic                 wrap;
  logic                 vote_now;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  // Third sample is the live line at vote time.
  generic__maj3 u_maj3 (
    .a (s0),
    .b (s1),
    .c (rxs),
    .y (vote)
  );

  assign wrap     = (sc == SC_LAST);
  assign vote_now = (sc == SC_VOTE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sc         <= '0;
      bi         <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (baud_tick) begin
        if (sc == SC_S0) s0 <= rxs;
        if (sc == SC_S1) s1 <= rxs;
        sc <= wrap ? '0 : sc + SC_ONE;
        unique case (state)
          ST_IDLE: begin
            // Detection tick is sample 0.
            sc <= '0;
            if (!rxs) begin
              state <= ST_START;
              sc    <= SC_ONE;
            end
          end
          ST_START: begin
            if (vote_now && vote) begin
              state <= ST_IDLE;
              sc    <= '0;
            end else if (wrap) begin
              state <= ST_DATA;
              bi    <= '0;
            end
          end
          ST_DATA: begin
            if (vote_now) shreg[bi] <= vote;
            if (wrap) begin
              if (bi == BI_LAST) begin
                state <= ST_STOP;
                bi    <= '0;
              end else begin
                bi <= bi + BI_ONE;
              end
            end
          end
          ST_STOP: begin
            // Leave mid-stop so the next start edge is caught early.
            if (vote_now) begin
              data_out <= shreg;
              sc       <= '0;
              if (vote) begin
                data_valid <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            sc <= '0;
            if (rxs) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            sc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_vote3.sv
// Self-checking bench for uart_rx_vote3 (8 data bits, 16x oversample).
// Table-driven frames plus hand sequences; scoreboard of expected pulses.
module tb_uart_rx_vote3;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_vote3 #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         glitch;
    int         gap;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_en = 0;
  vec_t   tbl[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse monitor: pops the scoreboard on every output pulse.
  always @(negedge clk) begin
    if (mon_en && (data_valid || frame_err)) begin
      exp_t e;
      check("pulse_exclusive", 64'(data_valid & frame_err), 64'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        check("pulse_kind", 64'(frame_err), 64'(e.is_err));
        check("pulse_data", 64'(data_out), 64'(e.data));
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_at_pulse", 64'(busy), 64'(e.is_err));
      end
    end
  end

  task automatic drive_cycle(input bit v);
    @(posedge clk);
    #1;
    rx_in = v;
  endtask

  function automatic bit frame_bit(input vec_t v, input int i);
    bit b;
    if (i < 16) b = 1'b0;
    else if (i < 144) b = v.data[(i - 16) / 16];
    else b = v.stop_ok;
    if (i == v.glitch) b = ~b;
    return b;
  endfunction

  // Drives one 160-cycle frame; pushes the expected pulse at its start.
  task automatic send_frame(input vec_t v);
    exp_t e;
    repeat (v.gap) drive_cycle(1'b1);
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        e.is_err = !v.stop_ok;
        e.data   = v.data;
        e.cyc    = cyc + 156;
        q.push_back(e);
      end
      rx_in = frame_bit(v, i);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] last_data;

    tbl[0] = '{8'hA5, 1'b1, -1,  10};
    tbl[1] = '{8'h3C, 1'b1, 56,  10};
    tbl[2] = '{8'h96, 1'b1, 23,   8};
    tbl[3] = '{8'hE7, 1'b1, 153,  8};
    tbl[4] = '{8'h42, 1'b1, 8,    8};
    tbl[5] = '{8'h00, 1'b1, -1,   8};
    tbl[6] = '{8'hFF, 1'b1, -1,   0};
    tbl[7] = '{8'h81, 1'b1, -1,   0};

    rx_in     = 1'b1;
    baud_tick = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_data_valid", 64'(data_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int t = 0; t < 8; t++) send_frame(tbl[t]);
    last_data = tbl[7].data;
    drain("table_drain");
    repeat (20) drive_cycle(1'b1);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("held_data", 64'(data_out), 64'(last_data));

    // False start: 3-cycle low pulse is out-voted at the centre.
    repeat (3) drive_cycle(1'b0);
    repeat (2) drive_cycle(1'b1);
    @(negedge clk);
    check("false_start_busy", 64'(busy), 64'd1);
    repeat (20) drive_cycle(1'b1);
    @(negedge clk);
    check("false_start_idle", 64'(busy), 64'd0);
    check("false_start_data", 64'(data_out), 64'(last_data));

    // Framing error followed by a held-low break.
    v = '{8'h55, 1'b0, -1, 10};
    send_frame(v);
    repeat (40) drive_cycle(1'b0);
    @(negedge clk);
    check("break_hold", 64'(busy), 64'd1);
    check("break_data", 64'(data_out), 64'h55);
    check("break_queue", 64'(q.size()), 64'd0);
    repeat (20) drive_cycle(1'b1);
    @(negedge clk);
    check("break_release", 64'(busy), 64'd0);
    v = '{8'h0F, 1'b1, -1, 5};
    send_frame(v);
    drain("after_break_drain");

    // Reset during bit 4 of an unscored frame.
    v = '{8'hC3, 1'b1, -1, 0};
    repeat (5) drive_cycle(1'b1);
    for (int i = 0; i < 85; i++) drive_cycle(frame_bit(v, i));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_data_out", 64'(data_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(data_valid), 64'd0);
    check("midrst_ferr", 64'(frame_err), 64'd0);
    repeat (30) drive_cycle(1'b1);
    v = '{8'h5A, 1'b1, -1, 5};
    send_frame(v);
    drain("after_reset_drain");
    repeat (20) drive_cycle(1'b1);
    @(negedge clk);
    check("final_data", 64'(data_out), 64'h5A);
    check("final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
